// File: rtl/bp_nonsynth_commit_matcher_if.sv
// Bundle of commit, writeback and resolved-record signals for the commit matcher.
// The producer/consumer side uses the master modport. The matcher uses the slave modport.
interface bp_nonsynth_commit_matcher_if #(
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32,
  parameter int data_width_p  = 64
);
  logic                     commit_v_i;
  logic [vaddr_width_p-1:0] commit_pc_i;
  logic [instr_width_p-1:0] commit_instr_i;
  logic                     commit_ird_w_v_i;
  logic                     commit_frd_w_v_i;
  logic                     commit_trap_i;
  logic [63:0]              commit_cause_i;
  logic                     commit_ready_o;
  logic                     ird_w_v_i;
  logic [4:0]               ird_addr_i;
  logic [data_width_p-1:0]  ird_data_i;
  logic                     frd_w_v_i;
  logic [4:0]               frd_addr_i;
  logic [data_width_p-1:0]  frd_data_i;
  logic                     v_o;
  logic                     yumi_i;
  logic [vaddr_width_p-1:0] pc_o;
  logic [instr_width_p-1:0] instr_o;
  logic                     trap_o;
  logic [63:0]              cause_o;
  logic                     rd_w_v_o;
  logic                     rd_fp_o;
  logic [4:0]               rd_addr_o;
  logic [data_width_p-1:0]  rd_data_o;
  logic [2:0]               error_o;
  logic [1:0]               wd_state_o;

  // Record handshake: a record transfers in a cycle where v_o=1 and yumi_i=1.
  // v_o never depends on yumi_i. The outputs hold while v_o=1 and yumi_i=0.
  modport master (
    output commit_v_i, commit_pc_i, commit_instr_i, commit_ird_w_v_i, commit_frd_w_v_i,
           commit_trap_i, commit_cause_i, ird_w_v_i, ird_addr_i, ird_data_i,
           frd_w_v_i, frd_addr_i, frd_data_i, yumi_i,
    input  commit_ready_o, v_o, pc_o, instr_o, trap_o, cause_o, rd_w_v_o, rd_fp_o,
           rd_addr_o, rd_data_o, error_o, wd_state_o
  );
  modport slave (
    input  commit_v_i, commit_pc_i, commit_instr_i, commit_ird_w_v_i, commit_frd_w_v_i,
           commit_trap_i, commit_cause_i, ird_w_v_i, ird_addr_i, ird_data_i,
           frd_w_v_i, frd_addr_i, frd_data_i, yumi_i,
    output commit_ready_o, v_o, pc_o, instr_o, trap_o, cause_o, rd_w_v_o, rd_fp_o,
           rd_addr_o, rd_data_o, error_o, wd_state_o
  );
endinterface

// File: rtl/bp_nonsynth_commit_matcher.sv
// Pairs in-order commit records with per-register writeback data and presents resolved
// records to the downstream checker. Overflow and stuck-head conditions raise sticky errors.
module bp_nonsynth_commit_matcher #(
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32,
  parameter int data_width_p  = 64,
  parameter int commit_els_p  = 16,
  parameter int wb_els_p      = 4,
  parameter int timeout_p     = 1024
) (
  input logic clk_i,
  input logic reset_i,
  bp_nonsynth_commit_matcher_if.slave io
);
  localparam int cptr_w = $clog2(commit_els_p);
  localparam int wptr_w = $clog2(wb_els_p);
  localparam int cnt_w  = $clog2(timeout_p) + 1;
  localparam logic [cptr_w:0] c_one = 1;
  localparam logic [wptr_w:0] w_one = 1;
  localparam logic [cnt_w-1:0] cnt_one  = 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(timeout_p - 1);

  typedef enum logic [1:0] {WD_IDLE = 2'd0, WD_WAIT = 2'd1, WD_HUNG = 2'd2} wd_state_e;

  logic [vaddr_width_p-1:0] c_pc_q    [commit_els_p];
  logic [instr_width_p-1:0] c_instr_q [commit_els_p];
  logic                     c_ird_q   [commit_els_p];
  logic                     c_frd_q   [commit_els_p];
  logic                     c_trap_q  [commit_els_p];
  logic [63:0]              c_cause_q [commit_els_p];
  logic [cptr_w:0]          c_wptr_q, c_rptr_q;

  logic [data_width_p-1:0] iwb_mem_q [32][wb_els_p];
  logic [data_width_p-1:0] fwb_mem_q [32][wb_els_p];
  logic [wptr_w:0]         iwb_wptr_q [32];
  logic [wptr_w:0]         iwb_rptr_q [32];
  logic [wptr_w:0]         fwb_wptr_q [32];
  logic [wptr_w:0]         fwb_rptr_q [32];

  wd_state_e        state_q, state_d;
  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic [2:0]       err_q;

  logic [cptr_w-1:0]        ridx, widx;
  logic [instr_width_p-1:0] head_instr;
  logic [4:0]               head_rd;
  logic c_empty, c_full, c_enq, deq;
  logic need_i, need_f, head_ok;
  logic i_full, f_full, i_enq, f_enq, i_deq, f_deq;
  logic wb_drop, timeout_set;

  function automatic logic wb_full(logic [wptr_w:0] w, logic [wptr_w:0] r);
    return (w[wptr_w] != r[wptr_w]) && (w[wptr_w-1:0] == r[wptr_w-1:0]);
  endfunction

  assign ridx       = c_rptr_q[cptr_w-1:0];
  assign widx       = c_wptr_q[cptr_w-1:0];
  assign head_instr = c_instr_q[ridx];
  assign head_rd    = head_instr[11:7];
  assign c_empty    = (c_wptr_q == c_rptr_q);
  assign c_full     = (c_wptr_q[cptr_w] != c_rptr_q[cptr_w]) &&
                      (widx == ridx);
  assign c_enq      = io.commit_v_i & ~c_full;

  // Traps and x0 destinations carry no writeback; f0 is a real FP register.
  assign need_i  = c_ird_q[ridx] & ~c_trap_q[ridx] & (head_rd != 5'd0);
  assign need_f  = c_frd_q[ridx] & ~c_trap_q[ridx];
  assign head_ok = ~c_empty &
                   (~(need_i | need_f) |
                    (need_i & (iwb_wptr_q[head_rd] != iwb_rptr_q[head_rd])) |
                    (need_f & (fwb_wptr_q[head_rd] != fwb_rptr_q[head_rd])));
  assign deq     = io.yumi_i & head_ok;

  assign i_full  = wb_full(iwb_wptr_q[io.ird_addr_i], iwb_rptr_q[io.ird_addr_i]);
  assign f_full  = wb_full(fwb_wptr_q[io.frd_addr_i], fwb_rptr_q[io.frd_addr_i]);
  assign i_enq   = io.ird_w_v_i & (io.ird_addr_i != 5'd0) & ~i_full;
  assign f_enq   = io.frd_w_v_i & ~f_full;
  assign i_deq   = deq & need_i;
  assign f_deq   = deq & need_f;
  assign wb_drop = (io.ird_w_v_i & (io.ird_addr_i != 5'd0) & i_full) |
                   (io.frd_w_v_i & f_full);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      c_wptr_q <= '0;
      c_rptr_q <= '0;
      err_q    <= '0;
      for (int r = 0; r < 32; r++) begin
        iwb_wptr_q[r] <= '0;
        iwb_rptr_q[r] <= '0;
        fwb_wptr_q[r] <= '0;
        fwb_rptr_q[r] <= '0;
      end
    end else begin
      if (c_enq) c_wptr_q <= c_wptr_q + c_one;
      if (deq)   c_rptr_q <= c_rptr_q + c_one;
      if (i_enq) iwb_wptr_q[io.ird_addr_i] <= iwb_wptr_q[io.ird_addr_i] + w_one;
      if (i_deq) iwb_rptr_q[head_rd] <= iwb_rptr_q[head_rd] + w_one;
      if (f_enq) fwb_wptr_q[io.frd_addr_i] <= fwb_wptr_q[io.frd_addr_i] + w_one;
      if (f_deq) fwb_rptr_q[head_rd] <= fwb_rptr_q[head_rd] + w_one;
      err_q <= err_q | {timeout_set, wb_drop, io.commit_v_i & c_full};
    end
  end

  // Storage arrays need no reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (c_enq) begin
      c_pc_q[widx]    <= io.commit_pc_i;
      c_instr_q[widx] <= io.commit_instr_i;
      c_ird_q[widx]   <= io.commit_ird_w_v_i;
      c_frd_q[widx]   <= io.commit_frd_w_v_i;
      c_trap_q[widx]  <= io.commit_trap_i;
      c_cause_q[widx] <= io.commit_cause_i;
    end
    if (i_enq)
      iwb_mem_q[io.ird_addr_i][iwb_wptr_q[io.ird_addr_i][wptr_w-1:0]] <= io.ird_data_i;
    if (f_enq)
      fwb_mem_q[io.frd_addr_i][fwb_wptr_q[io.frd_addr_i][wptr_w-1:0]] <= io.frd_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= WD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Only an unmatched head counts; a matched head stalled by the consumer does not.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timeout_set = 1'b0;
    case (state_q)
      WD_IDLE, WD_WAIT: begin
        if (c_empty || head_ok) begin
          state_d = WD_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_one;
          if (cnt_d == cnt_last) begin
            state_d     = WD_HUNG;
            timeout_set = 1'b1;
          end else begin
            state_d = WD_WAIT;
          end
        end
      end
      WD_HUNG: begin
        if (c_empty || head_ok) begin
          state_d = WD_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = WD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign io.commit_ready_o = ~c_full;
  assign io.v_o            = head_ok;
  assign io.pc_o           = c_pc_q[ridx];
  assign io.instr_o        = head_instr;
  assign io.trap_o         = c_trap_q[ridx];
  assign io.cause_o        = c_cause_q[ridx];
  assign io.rd_w_v_o       = need_i | need_f;
  assign io.rd_fp_o        = need_f;
  assign io.rd_addr_o      = head_rd;
  assign io.rd_data_o      = need_f ? fwb_mem_q[head_rd][fwb_rptr_q[head_rd][wptr_w-1:0]] :
                             need_i ? iwb_mem_q[head_rd][iwb_rptr_q[head_rd][wptr_w-1:0]] :
                                      '0;
  assign io.error_o        = err_q;
  assign io.wd_state_o     = state_q;
endmodule
